uart_word_rx_ctrl: RTL and testbench
====================================

Name: uart_word_rx_ctrl

Overview:
Sequencing controller that sits between the UART byte receiver and the word consumer. It accepts single-cycle byte strobes, assembles WORD_BYTES bytes MSB-first into one word, and presents that word on a valid/ready handshake with a single holding register. It aborts a partial word on inter-byte timeout, on a byte error, or when disabled. It also keeps sticky error/overflow flags and a count of delivered words.

Parameters:
WORD_BYTES, 4, bytes per word; word width is 8*WORD_BYTES; legal range 2..4.
TIMEOUT_CYCLES, 50000, maximum idle clk cycles between bytes of one word before the partial word is discarded.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset, asynchronous and active-low.
enable  in  1  1 = accept bytes; 0 = ignore bytes and clear any partial word.
rx_byte  in  8  byte from the byte receiver.
rx_byte_valid  in  1  single-cycle strobe; rx_byte is valid this cycle.
rx_byte_error  in  1  qualifies rx_byte_valid; 1 = framing/stop-bit error on this byte.
word_data  out  8*WORD_BYTES  assembled word; stable while word_valid=1.
word_valid  out  1  word_data holds an undelivered word.
word_ready  in  1  consumer accepts; a transfer occurs when word_valid & word_ready.
partial_bytes  out  3  bytes collected toward the current word (0..WORD_BYTES-1).
busy  out  1  1 while in state COLLECT.
timeout_pulse  out  1  one-cycle pulse when a partial word is discarded by timeout.
error_pulse  out  1  one-cycle pulse when a partial or new word is discarded by rx_byte_error.
overflow_flag  out  1  sticky; a completed word was dropped because the holding register was full.
error_flag  out  1  sticky; set with any timeout_pulse or error_pulse.
clear_flags  in  1  synchronous clear of overflow_flag and error_flag.
word_count  out  CNT_W  number of handshake transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): word_data=0, word_valid=0, partial_bytes=0, busy=0, both pulses=0, both flags=0, word_count=0, timeout counter=0, state=IDLE.
- FSM states:
  - IDLE: no partial word.
  - COLLECT: 1..WORD_BYTES-1 bytes held.
- Good byte (rx_byte_valid=1, rx_byte_error=0, enable=1):
  - Shift: assembly reg = {assembly[8*WORD_BYTES-9:0], rx_byte}; partial_bytes+1; timeout counter cleared.
  - IDLE -> COLLECT on the first byte.
  - On the WORD_BYTES-th byte: the word completes; state -> IDLE; partial_bytes -> 0.
- Word completion:
  - Holding register empty, or emptying this same cycle (word_valid & word_ready): word_data loads the completed word on the next edge; word_valid=1. Latency is one clk from the last byte strobe to word_valid.
  - Holding register full and word_ready=0: completed word dropped; word_data unchanged; overflow_flag set.
- Handshake:
  - word_valid stays high until a cycle with word_ready=1.
  - On transfer: word_count+1; word_valid->0 unless a new word loads in the same cycle.
  - word_ready while word_valid=0 has no effect.
- Error byte (rx_byte_valid=1, rx_byte_error=1, enable=1): partial word discarded; state -> IDLE; partial_bytes=0; error_pulse=1 next cycle; error_flag set. The byte is never stored.
- Timeout:
  - In COLLECT, the counter increments each cycle with no byte.
  - When the counter reaches TIMEOUT_CYCLES-1: discard the partial word, go to IDLE, clear the counter, timeout_pulse=1 for one cycle, set error_flag.
  - The counter is held at 0 in IDLE.
- Simultaneous events:
  - Byte strobe in the same cycle as timeout expiry: the byte wins, no timeout, counter cleared.
  - clear_flags in the same cycle as a flag-set event: set wins.
- enable=0:
  - Byte strobes ignored; partial word discarded; state IDLE; counter 0; no pulses.
  - The holding register and handshake keep operating.
- Mid-word reset: all state is lost; the next byte after reset release starts a new word.

Test Plan:
- Bytes 0xDE,0xAD,0xBE,0xEF spaced 10 cycles apart, word_ready=1 -> word_valid for 1 cycle, word_data=0xDEADBEEF one clk after the 4th strobe, word_count=1.
- Two words 0x11223344 then 0x55667788 with word_ready=0 -> word_data stays 0x11223344, overflow_flag=1; then word_ready=1 -> transfer, word_count=1; clear_flags -> overflow_flag=0.
- TIMEOUT_CYCLES=100: bytes 0x01,0x02, then 100 idle cycles -> timeout_pulse once at cycle 99 after the last byte, partial_bytes=0, error_flag=1; then 0xA1..0xA4 -> word 0xA1A2A3A4.
- Bytes 0x01,0x02 then a byte with rx_byte_error=1 -> error_pulse once, no word out; the next 4 good bytes assemble correctly.
- Drop enable after 3 bytes, raise it again, send 4 bytes -> only the new 4 bytes form the word; rst_n pulsed mid-word -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_word_rx_ctrl.sv
// uart_word_rx_ctrl
// Collects single-cycle byte strobes from a UART byte receiver into
// WORD_BYTES-wide words (first byte lands in the most significant byte),
// and offers each word to a consumer through a one-entry valid/ready
// holding register. Partial words are abandoned on an inter-byte timeout,
// on a byte flagged with a framing error, or when the block is disabled.
// Sticky overflow/error flags and a delivered-word counter are kept.
module uart_word_rx_ctrl #(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_byte_valid,
  input  logic                    rx_byte_error,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [2:0]              partial_bytes,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic                    error_pulse,
  output logic                    overflow_flag,
  output logic                    error_flag,
  input  logic                    clear_flags,
  output logic [CNT_W-1:0]        word_count
);

  localparam int WW = 8 * WORD_BYTES;
  // Assembly only ever holds the first WORD_BYTES-1 bytes; the final byte
  // is taken straight from rx_byte when the word completes.
  localparam int AW = WW - 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [2:0]    LAST_BYTE = 3'(WORD_BYTES - 1);
  localparam logic [2:0]    PB_ONE    = 3'd1;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    asm_q, asm_d;
  logic [2:0]       partial_q, partial_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             tpulse_q, tpulse_d;
  logic             epulse_q, epulse_d;

  logic [WW-1:0]    word_data_q, word_data_d;
  logic             word_valid_q, word_valid_d;
  logic             ovf_q, ovf_d;
  logic             errf_q, errf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             byte_good;
  logic             byte_bad;
  logic             word_done;
  logic [WW-1:0]    done_word;
  logic             transfer;
  logic             ovf_set;

  assign byte_good = rx_byte_valid & ~rx_byte_error;
  assign byte_bad  = rx_byte_valid &  rx_byte_error;
  assign done_word = {asm_q, rx_byte};
  assign transfer  = word_valid_q & word_ready;

  // Collection FSM: byte assembly, inter-byte timeout and abort handling.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    partial_d = partial_q;
    tmo_d     = tmo_q;
    tpulse_d  = 1'b0;
    epulse_d  = 1'b0;
    word_done = 1'b0;

    if (!enable) begin
      // Disabled: bytes are ignored and any partial word is thrown away
      // silently (no pulse, no flag).
      state_d   = S_IDLE;
      asm_d     = '0;
      partial_d = '0;
      tmo_d     = '0;
    end else if (byte_good) begin
      // A good byte always beats a timeout expiring in the same cycle.
      tmo_d = '0;
      if (partial_q == LAST_BYTE) begin
        word_done = 1'b1;
        state_d   = S_IDLE;
        asm_d     = '0;
        partial_d = '0;
      end else begin
        asm_d     = done_word[AW-1:0];
        partial_d = partial_q + PB_ONE;
        state_d   = S_COLLECT;
      end
    end else if (byte_bad) begin
      // The errored byte is never stored; report even from IDLE since the
      // byte itself would have started a new word.
      state_d   = S_IDLE;
      asm_d     = '0;
      partial_d = '0;
      tmo_d     = '0;
      epulse_d  = 1'b1;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (tmo_q == TMO_LAST) begin
            state_d   = S_IDLE;
            asm_d     = '0;
            partial_d = '0;
            tmo_d     = '0;
            tpulse_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        default: begin
          tmo_d = '0;
        end
      endcase
    end
  end

  // Holding register, handshake, sticky flags and delivered-word counter.
  always_comb begin
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    ovf_set      = 1'b0;
    count_d      = count_q;

    if (transfer) begin
      word_valid_d = 1'b0;
      count_d      = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // A slot freed by this cycle's transfer may be refilled immediately.
    if (word_done) begin
      if (!word_valid_q || transfer) begin
        word_data_d  = done_word;
        word_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    // Setting a flag takes priority over clearing it.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (tpulse_d || epulse_d) begin
      errf_d = 1'b1;
    end else if (clear_flags) begin
      errf_d = 1'b0;
    end else begin
      errf_d = errf_q;
    end
  end

  // State register for the collection side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      asm_q     <= '0;
      partial_q <= '0;
      tmo_q     <= '0;
      tpulse_q  <= 1'b0;
      epulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      partial_q <= partial_d;
      tmo_q     <= tmo_d;
      tpulse_q  <= tpulse_d;
      epulse_q  <= epulse_d;
    end
  end

  // State register for the delivery side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      errf_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      ovf_q        <= ovf_d;
      errf_q       <= errf_d;
      count_q      <= count_d;
    end
  end

  assign word_data     = word_data_q;
  assign word_valid    = word_valid_q;
  assign partial_bytes = partial_q;
  assign busy          = (state_q == S_COLLECT);
  assign timeout_pulse = tpulse_q;
  assign error_pulse   = epulse_q;
  assign overflow_flag = ovf_q;
  assign error_flag    = errf_q;
  assign word_count    = count_q;

endmodule

// File: tb/tb_uart_word_rx_ctrl.sv
// Bench for uart_word_rx_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a byte-queue reference model.
module tb_uart_word_rx_ctrl;

  localparam int WB = 4;
  localparam int TC = 100;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_byte_valid = 1'b0;
  logic          rx_byte_error = 1'b0;
  logic          word_ready = 1'b0;
  logic          clear_flags = 1'b0;
  logic [8*WB-1:0] word_data;
  logic          word_valid;
  logic [2:0]    partial_bytes;
  logic          busy;
  logic          timeout_pulse;
  logic          error_pulse;
  logic          overflow_flag;
  logic          error_flag;
  logic [CW-1:0] word_count;

  uart_word_rx_ctrl #(
    .WORD_BYTES(WB),
    .TIMEOUT_CYCLES(TC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte_error(rx_byte_error),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .partial_bytes(partial_bytes),
    .busy(busy),
    .timeout_pulse(timeout_pulse),
    .error_pulse(error_pulse),
    .overflow_flag(overflow_flag),
    .error_flag(error_flag),
    .clear_flags(clear_flags),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model state.
  logic [7:0]      m_part[$];
  int              m_idle;
  logic [8*WB-1:0] m_word;
  bit              m_valid;
  logic [CW-1:0]   m_count;
  bit              m_tp, m_ep, m_ovf, m_ef;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_part.delete();
    m_idle  = 0;
    m_word  = '0;
    m_valid = 0;
    m_count = '0;
    m_tp = 0; m_ep = 0; m_ovf = 0; m_ef = 0;
  endtask

  // One clock of behaviour, from the current inputs.
  task automatic model_step();
    bit xfer, done, tp, ep, ovf_set;
    logic [8*WB-1:0] w;
    xfer = m_valid && word_ready;
    done = 0; tp = 0; ep = 0; ovf_set = 0; w = '0;
    if (!enable) begin
      m_part.delete();
      m_idle = 0;
    end else if (rx_byte_valid && !rx_byte_error) begin
      m_part.push_back(rx_byte);
      m_idle = 0;
      if (m_part.size() == WB) begin
        foreach (m_part[i]) w = (w << 8) | (8*WB)'(m_part[i]);
        done = 1;
        m_part.delete();
      end
    end else if (rx_byte_valid) begin
      m_part.delete();
      m_idle = 0;
      ep = 1;
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == TC) begin
        m_part.delete();
        m_idle = 0;
        tp = 1;
      end
    end
    if (xfer) begin
      m_valid = 0;
      m_count = m_count + 16'(1);
    end
    if (done) begin
      if (!m_valid) begin
        m_word  = w;
        m_valid = 1;
      end else begin
        ovf_set = 1;
      end
    end
    if (clear_flags) begin
      m_ovf = 0;
      m_ef  = 0;
    end
    if (ovf_set) m_ovf = 1;
    if (tp || ep) m_ef = 1;
    m_tp = tp;
    m_ep = ep;
  endtask

  task automatic check_all();
    chk("word_valid", 64'(word_valid), 64'(m_valid));
    chk("word_data", 64'(word_data), 64'(m_word));
    chk("partial_bytes", 64'(partial_bytes), 64'(m_part.size()));
    chk("busy", 64'(busy), 64'(m_part.size() > 0));
    chk("timeout_pulse", 64'(timeout_pulse), 64'(m_tp));
    chk("error_pulse", 64'(error_pulse), 64'(m_ep));
    chk("overflow_flag", 64'(overflow_flag), 64'(m_ovf));
    chk("error_flag", 64'(error_flag), 64'(m_ef));
    chk("word_count", 64'(word_count), 64'(m_count));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [7:0] b, input bit err);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    rx_byte_error = err;
    cyc();
    rx_byte_valid = 1'b0;
    rx_byte_error = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(8'(w >> (8*i)), 1'b0);
  endtask

  initial begin
    int mode;
    int pct;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_word_valid", 64'(word_valid), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    idle(3);

    // Word spaced 10 cycles per byte, consumer ready.
    word_ready = 1'b1;
    send(8'hDE, 1'b0); idle(9);
    send(8'hAD, 1'b0); idle(9);
    send(8'hBE, 1'b0); idle(9);
    send(8'hEF, 1'b0);
    chk("t1_valid", 64'(word_valid), 64'd1);
    chk("t1_data", 64'(word_data), 64'hDEADBEEF);
    cyc();
    chk("t1_valid_after", 64'(word_valid), 64'd0);
    chk("t1_count", 64'(word_count), 64'd1);

    // Overflow: two words while the consumer stalls.
    word_ready = 1'b0;
    send_word(32'h11223344);
    send_word(32'h55667788);
    idle(2);
    chk("t2_data_held", 64'(word_data), 64'h11223344);
    chk("t2_overflow", 64'(overflow_flag), 64'd1);
    word_ready = 1'b1;
    cyc();
    chk("t2_count", 64'(word_count), 64'd2);
    chk("t2_valid_after", 64'(word_valid), 64'd0);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    chk("t2_ovf_cleared", 64'(overflow_flag), 64'd0);

    // Inter-byte timeout after two bytes.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    for (int k = 1; k <= TC; k++) begin
      cyc();
      chk("t3_tpulse", 64'(timeout_pulse), 64'(k == TC));
    end
    chk("t3_partial", 64'(partial_bytes), 64'd0);
    chk("t3_error_flag", 64'(error_flag), 64'd1);
    send_word(32'hA1A2A3A4);
    chk("t3_word", 64'(word_data), 64'hA1A2A3A4);
    chk("t3_valid", 64'(word_valid), 64'd1);
    idle(2);

    // Error byte aborts a partial word.
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    chk("t4_epulse", 64'(error_pulse), 64'd1);
    chk("t4_valid", 64'(word_valid), 64'd0);
    cyc();
    chk("t4_epulse_once", 64'(error_pulse), 64'd0);
    send_word(32'h10111213);
    chk("t4_word", 64'(word_data), 64'h10111213);
    idle(2);

    // Enable drop mid-word.
    send(8'hF0, 1'b0); send(8'hF1, 1'b0); send(8'hF2, 1'b0);
    enable = 1'b0;
    send(8'hF3, 1'b0);
    chk("t5_partial_dis", 64'(partial_bytes), 64'd0);
    enable = 1'b1;
    send_word(32'hC0C1C2C3);
    chk("t5_word", 64'(word_data), 64'hC0C1C2C3);
    idle(2);

    // Asynchronous reset mid-word.
    send(8'h77, 1'b0); send(8'h78, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_partial", 64'(partial_bytes), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_count", 64'(word_count), 64'd0);
    chk("t6_data", 64'(word_data), 64'd0);
    check_all();
    @(posedge clk); #1; check_all();
    rst_n = 1'b1;
    send_word(32'hE0E1E2E3);
    chk("t6_word", 64'(word_data), 64'hE0E1E2E3);
    idle(2);

    // Randomized traffic with varying byte density.
    for (int blk = 0; blk < 12; blk++) begin
      mode = int'($urandom_range(0, 2));
      pct  = (mode == 0) ? 500 : (mode == 1) ? 100 : 5;
      for (int c = 0; c < 300; c++) begin
        enable        = ($urandom_range(0, 49) != 0);
        rx_byte_valid = ($urandom_range(0, 999) < pct);
        rx_byte_error = ($urandom_range(0, 11) == 0);
        rx_byte       = 8'($urandom);
        word_ready    = ($urandom_range(0, 1) == 1);
        clear_flags   = ($urandom_range(0, 39) == 0);
        cyc();
      end
    end
    rx_byte_valid = 1'b0;
    rx_byte_error = 1'b0;
    clear_flags   = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
